fifo_stream_reader: RTL and testbench

Read-side adapter for the project's FIFOs. It drains a FIFO read port that has registered, one-cycle-latency read data and presents the words as a valid/ready stream to downstream logic such as pixel pipelines and UART/SPI transmitters. A 2-entry output buffer absorbs the read latency, so the block sustains one beat per cycle when the FIFO is non-empty and the sink is ready. It sits in the read clock domain, directly behind the FIFO's rd_en/rd_data/empty port.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/stream_skid_buf.sv | 81 ++++++++
 rtl/fifo_stream_reader.sv | 103 ++++++++++
 tb/tb_fifo_stream_reader.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side adapters: buffer occupancy encoding and
// the default statistics counter width.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int unsigned STAT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry head/skid output buffer with occupancy tracking; head is the
// stream output register, skid holds the word that arrives while head is busy.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            occ_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush_i) begin
      occ_d = EMPTY;
    end else if (push_i && !pop_i) begin
      case (occ_q)
        EMPTY: begin
          head_d = push_data_i;
          occ_d  = ONE;
        end
        ONE: begin
          skid_d = push_data_i;
          occ_d  = TWO;
        end
        default: ;
      endcase
    end else if (pop_i && !push_i) begin
      head_d = skid_q;
      case (occ_q)
        TWO:     occ_d = ONE;
        ONE:     occ_d = EMPTY;
        default: ;
      endcase
    end else if (pop_i && push_i) begin
      // Occupancy is unchanged; with a full buffer the skid word advances first.
      if (occ_q == TWO) begin
        head_d = skid_q;
        skid_d = push_data_i;
      end else begin
        head_d = push_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = (occ_q != EMPTY);
  assign head_o  = head_q;

  overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && !flush_i && occ_q == TWO));

  underflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && occ_q == EMPTY));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port with one-cycle registered read data into a
// valid/ready stream. Optional beat/stall counters: FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  parameter int unsigned STAT_WIDTH = STAT_WIDTH_DEFAULT
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
`ifdef FIFO_STREAM_READER_STATS_EN
  output logic [STAT_WIDTH-1:0] beat_cnt_o,
  output logic [STAT_WIDTH-1:0] stall_cnt_o,
`endif
  input  logic                  m_ready_i
);

  logic       run_q, run_d;
  logic       inflight_q, inflight_d;
  logic       fire;
  logic       capture;
  logic       rd_en;
  logic [1:0] occ;
  logic [2:0] level;

  assign fire = m_valid_o && m_ready_i;

  // Pop only if the word it brings back is guaranteed a free slot once
  // this cycle's transfer has drained the buffer.
  always_comb begin
    capture    = inflight_q && !flush_i;
    level      = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, fire};
    rd_en      = run_q && !flush_i && !fifo_empty_i && (level <= 3'd1);
    run_d      = 1'b1;
    inflight_d = rd_en;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
    end
  end

  assign fifo_rd_en_o = rd_en;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (capture),
    .push_data_i (fifo_rd_data_i),
    .pop_i       (fire),
    .occ_o       (occ),
    .valid_o     (m_valid_o),
    .head_o      (m_data_o)
  );

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [STAT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Counters saturate and survive flush; only reset clears them.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fire && (beat_cnt_q != '1)) begin
      beat_cnt_d = beat_cnt_q + STAT_WIDTH'(1);
    end
    if (m_valid_o && !m_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt_o  = beat_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO with registered read data and
// an in-order scoreboard of pushed words. Stats test needs FIFO_STREAM_READER_STATS_EN.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic        fifo_empty;
  logic        m_valid;
  logic [15:0] m_data;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [3:0]  beat_cnt;
  logic [3:0]  stall_cnt;
`endif

  logic [15:0] mem [0:4095];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int          underflows = 0;
  logic [15:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (16)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .STAT_WIDTH (4)
`endif
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_empty_i   (fifo_empty),
    .flush_i        (flush),
    .m_valid_o      (m_valid),
    .m_data_o       (m_data),
`ifdef FIFO_STREAM_READER_STATS_EN
    .beat_cnt_o     (beat_cnt),
    .stall_cnt_o    (stall_cnt),
`endif
    .m_ready_i      (m_ready)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) begin
        underflows <= underflows + 1;
      end else begin
        fifo_rd_data <= mem[rd_ptr[11:0]];
        rd_ptr       <= rd_ptr + 1;
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic test_reset;
    int first_pop = -1;
    int first_beat = -1;
    int last_beat = -1;
    int beats = 0;
    logic [15:0] e;
    rst_n = 1'b0;
    flush = 1'b0;
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== 16'h0000 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h rd_en=%b, required 0 0000 0", m_valid, m_data, fifo_rd_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      tests++;
      if (fifo_rd_en === 1'b1 && fifo_empty) begin
        fails++;
        $display("FAIL rd_en_while_empty: cycle %0d rd_en=1, required 0", k);
      end
      if (fifo_rd_en === 1'b1 && first_pop < 0) first_pop = k;
      if (m_valid === 1'b1 && m_ready) begin
        if (first_beat < 0) first_beat = k;
        last_beat = k;
        beats++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL reset_beat: unexpected word %h, required none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            fails++;
            $display("FAIL reset_beat: data=%h, required %h", m_data, e);
          end
        end
      end
      @(negedge clk);
    end
    tests++;
    if (first_pop != 1) begin
      fails++;
      $display("FAIL first_pop_cycle: %0d, required 1", first_pop);
    end
    tests++;
    if (first_beat != first_pop + 2) begin
      fails++;
      $display("FAIL first_valid_cycle: %0d, required %0d", first_beat, first_pop + 2);
    end
    tests++;
    if (beats != 4 || last_beat != first_beat + 3) begin
      fails++;
      $display("FAIL reset_throughput: beats=%0d span=%0d, required 4 consecutive", beats, last_beat - first_beat + 1);
    end
  endtask

  task automatic test_backpressure;
    int pops = 0;
    int gaps = 0;
    logic [15:0] e;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(16'(16'h0100 + i));
    for (int k = 0; k < 10; k++) begin
      #1;
      tests++;
      if (fifo_rd_en === 1'b1 && fifo_empty) begin
        fails++;
        $display("FAIL rd_en_while_empty: bp cycle %0d", k);
      end
      if (fifo_rd_en === 1'b1) pops++;
      if (m_valid === 1'b1) begin
        tests++;
        if (m_data !== exp_q[0]) begin
          fails++;
          $display("FAIL held_data: data=%h, required %h", m_data, exp_q[0]);
        end
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (pops != 2) begin
      fails++;
      $display("FAIL bp_pop_count: %0d, required 2", pops);
    end
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_valid: %b, required 1", m_valid);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      #1;
      if (m_valid === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if (m_data !== e) begin
          fails++;
          $display("FAIL bp_order: data=%h, required %h", m_data, e);
        end
      end else begin
        gaps++;
      end
      @(negedge clk);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_drain_timeout: %0d words left, required 0", exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (gaps != 0) begin
      fails++;
      $display("FAIL bp_back_to_back: %0d idle cycles, required 0", gaps);
    end
  endtask

  task automatic test_random;
    int unsigned base;
    int unsigned fired = 0;
    logic [15:0] e;
    base = rd_ptr;
    for (int i = 0; i < 1000; i++) push_word(16'($urandom));
    for (int k = 0; k < 6000 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      tests++;
      if ((rd_ptr - base - fired) > 2) begin
        fails++;
        $display("FAIL held_words: %0d, required <= 2", rd_ptr - base - fired);
      end
      if (fifo_rd_en === 1'b1 && fifo_empty) begin
        fails++;
        $display("FAIL rd_en_while_empty: random cycle %0d", k);
      end
      if (m_valid === 1'b1 && m_ready) begin
        e = exp_q.pop_front();
        fired++;
        tests++;
        if (m_data !== e) begin
          fails++;
          $display("FAIL random_order: beat %0d data=%h, required %h", fired, m_data, e);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL random_timeout: %0d words left, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    m_ready = 1'b1;
  endtask

  task automatic test_flush;
    logic [15:0] e;
    repeat (2) @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(16'(16'h0A00 + i));
    #1;
    tests++;
    if (fifo_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL flush_pop0: rd_en=%b, required 1", fifo_rd_en);
    end
    @(negedge clk);
    #1;
    tests++;
    if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_pop1: rd_en=%b valid=%b, required 1 0", fifo_rd_en, m_valid);
    end
    @(negedge clk);
    #1;
    tests++;
    if (m_valid !== 1'b1 || m_data !== 16'h0A00 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL flush_pre: valid=%b data=%h rd_en=%b, required 1 0a00 0", m_valid, m_data, fifo_rd_en);
    end
    flush = 1'b1;
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL flush_rd_en: %b, required 0", fifo_rd_en);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL flush_post: valid=%b rd_en=%b, required 0 1", m_valid, fifo_rd_en);
    end
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    m_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
      if (m_valid === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if (m_data !== e) begin
          fails++;
          $display("FAIL flush_resume: data=%h, required %h", m_data, e);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL flush_timeout: %0d words left, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [15:0] e;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(16'(16'h0B00 + i));
    for (int k = 0; k < 5; k++) begin
      #1;
      if (m_valid === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if (m_data !== e) begin
          fails++;
          $display("FAIL pre_reset_order: data=%h, required %h", m_data, e);
        end
      end
      @(negedge clk);
    end
    #2;
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_burst_valid: %b, required 1", m_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: valid=%b rd_en=%b, required 0 0", m_valid, fifo_rd_en);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int unsigned p = rd_ptr; p < wr_ptr; p++) exp_q.push_back(mem[p[11:0]]);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      #1;
      if (m_valid === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if (m_data !== e) begin
          fails++;
          $display("FAIL post_reset_order: data=%h, required %h", m_data, e);
        end
      end
      @(negedge clk);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL post_reset_timeout: %0d words left, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

`ifdef FIFO_STREAM_READER_STATS_EN
  task automatic test_stats;
    int fires = 0;
    int stalls = 0;
    logic [15:0] e;
    logic [3:0] exp_beat;
    logic [3:0] exp_stall;
    rst_n = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (beat_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
      fails++;
      $display("FAIL stats_reset: beat=%0d stall=%0d, required 0 0", beat_cnt, stall_cnt);
    end
    for (int i = 0; i < 20; i++) push_word(16'(16'h0C00 + i));
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      m_ready = !(m_valid === 1'b1 && stalls < 3 && fires >= 5 * (stalls + 1));
      #1;
      if (m_valid === 1'b1 && !m_ready) stalls++;
      if (m_valid === 1'b1 && m_ready) begin
        e = exp_q.pop_front();
        fires++;
        tests++;
        if (m_data !== e) begin
          fails++;
          $display("FAIL stats_order: data=%h, required %h", m_data, e);
        end
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    exp_beat = (fires > 15) ? 4'd15 : 4'(fires);
    exp_stall = (stalls > 15) ? 4'd15 : 4'(stalls);
    tests++;
    if (fires != 20 || stalls != 3) begin
      fails++;
      $display("FAIL stats_stimulus: fires=%0d stalls=%0d, required 20 3", fires, stalls);
    end
    tests++;
    if (beat_cnt !== exp_beat) begin
      fails++;
      $display("FAIL beat_cnt: %0d, required %0d", beat_cnt, exp_beat);
    end
    tests++;
    if (stall_cnt !== exp_stall) begin
      fails++;
      $display("FAIL stall_cnt: %0d, required %0d", stall_cnt, exp_stall);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_backpressure();
    test_random();
    test_flush();
    test_async_reset();
`ifdef FIFO_STREAM_READER_STATS_EN
    test_stats();
`endif
    tests++;
    if (underflows != 0) begin
      fails++;
      $display("FAIL fifo_underflow: %0d pops while empty, required 0", underflows);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
